// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one async single-port RAM
// between two requesters. Build option: ARB_BACK_TO_BACK_EN.
// Ports: clk, rst_n (async, active low); per requester N:
//   reqN/weN/addrN/dinN in, gntN/rdataN/rvalidN out;
//   RAM side: ram_we/ram_addr/ram_din out (all flops), ram_dout in.
module ram_port_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] din0,
  output logic          gnt0,
  output logic [DW-1:0] rdata0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] din1,
  output logic          gnt1,
  output logic [DW-1:0] rdata1,
  output logic          rvalid1,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          rr_last_q, rr_last_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;

  logic elig0, elig1, can_grant;
  logic pick0, pick1;

  always_comb begin
    elig0 = req0;
    elig1 = req1;
`ifdef ARB_BACK_TO_BACK_EN
    can_grant = 1'b1;
    // The owner of the ending access still holds req with a
    // stale command; keep it out of this edge's decision.
    if (state_q == ACCESS) begin
      elig0 = req0 & ~gnt0_q;
      elig1 = req1 & ~gnt1_q;
    end
`else
    can_grant = (state_q == IDLE);
`endif
    // rr_last_q names the last winner; on contention the
    // other side wins.
    pick0 = can_grant & elig0 & (~elig1 | rr_last_q);
    pick1 = can_grant & elig1 & (~elig0 | ~rr_last_q);
  end

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;

    unique case (state_q)
      IDLE: ;
      ACCESS: begin
        state_d = IDLE;
        if (!ram_we_q) begin
          if (gnt0_q) begin
            rdata0_d  = ram_dout;
            rvalid0_d = 1'b1;
          end
          if (gnt1_q) begin
            rdata1_d  = ram_dout;
            rvalid1_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (1'b1)
      pick0: begin
        state_d    = ACCESS;
        gnt0_d     = 1'b1;
        rr_last_d  = 1'b0;
        ram_we_d   = we0;
        ram_addr_d = addr0;
        ram_din_d  = din0;
      end
      pick1: begin
        state_d    = ACCESS;
        gnt1_d     = 1'b1;
        rr_last_d  = 1'b1;
        ram_we_d   = we1;
        ram_addr_d = addr1;
        ram_din_d  = din1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench for ram_port_arbiter
// with a behavioural async RAM on the RAM port.
module tb_ram_port_arbiter;

`ifdef ARB_BACK_TO_BACK_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [3:0] addr0 = 0, addr1 = 0;
  logic [7:0] din0 = 0, din1 = 0;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;

  logic [7:0] mem [16];

  int vec = 0;
  int miss = 0;

  cmd_t       q0[$], q1[$];
  int         gcyc[$], gid[$];
  logic [7:0] rd0[$], rd1[$];
  int         dbl;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  ram_port_arbiter #(.AW(4), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .din0(din0),
    .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .din1(din1),
    .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  task automatic test_reset();
    logic [5:0] outs;
    @(negedge clk);
    outs = {ram_we, gnt0, gnt1, rvalid0, rvalid1, |ram_addr};
    vec++;
    if (outs !== 6'b0) begin
      miss++;
      $display("FAIL reset_hold: got %b want 000000", outs);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    outs = {ram_we, gnt0, gnt1, rvalid0, rvalid1, |ram_din};
    vec++;
    if (outs !== 6'b0) begin
      miss++;
      $display("FAIL reset_idle: got %b want 000000", outs);
    end
    req0 = 1; we0 = 1; addr0 = 4'd7; din0 = 8'h33;
    @(negedge clk);
    vec++;
    if (ram_we !== 1'b1) begin
      miss++;
      $display("FAIL reset_prewrite: ram_we got %b want 1", ram_we);
    end
    #2 rst_n = 1'b0;
    #1;
    outs = {ram_we, gnt0, gnt1, rvalid0, rvalid1, 1'b0};
    vec++;
    if (outs !== 6'b0) begin
      miss++;
      $display("FAIL reset_async: got %b want 000000", outs);
    end
    req0 = 0; we0 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec++;
    if ({ram_we, gnt0} !== 2'b0) begin
      miss++;
      $display("FAIL reset_release: got %b want 00", {ram_we, gnt0});
    end
  endtask

  task automatic test_write();
    req0 = 1; we0 = 1; addr0 = 4'd2; din0 = 8'hAA;
    @(negedge clk);
    vec++;
    if ({gnt0, gnt1, ram_we, ram_addr, ram_din} !== {3'b101, 4'd2, 8'hAA}) begin
      miss++;
      $display("FAIL write_access: got %b%b%b %h %h want 101 2 aa",
               gnt0, gnt1, ram_we, ram_addr, ram_din);
    end
    @(negedge clk);
    req0 = 0; we0 = 0;
    vec++;
    if ({gnt0, ram_we, ram_addr, ram_din} !== {2'b00, 4'd2, 8'hAA}) begin
      miss++;
      $display("FAIL write_after: got %b%b %h %h want 00 2 aa",
               gnt0, ram_we, ram_addr, ram_din);
    end
  endtask

  task automatic test_read();
    req0 = 1; we0 = 0; addr0 = 4'd2;
    @(negedge clk);
    vec++;
    if ({gnt0, ram_we, rvalid0} !== 3'b100) begin
      miss++;
      $display("FAIL read_access: got %b want 100", {gnt0, ram_we, rvalid0});
    end
    @(negedge clk);
    req0 = 0;
    vec++;
    if ({rvalid0, rvalid1, gnt0, rdata0} !== {3'b100, 8'hAA}) begin
      miss++;
      $display("FAIL read_data: got %b %h want 100 aa",
               {rvalid0, rvalid1, gnt0}, rdata0);
    end
    @(negedge clk);
    vec++;
    if ({rvalid0, rdata0} !== {1'b0, 8'hAA}) begin
      miss++;
      $display("FAIL read_hold: got %b %h want 0 aa", rvalid0, rdata0);
    end
  endtask

  // Two requesters following the handshake: each holds its command
  // until it has seen its grant at an edge, then moves on.
  task automatic run(input int ncyc);
    bit p0 = 0;
    bit p1 = 0;
    gcyc.delete(); gid.delete(); rd0.delete(); rd1.delete();
    dbl = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (p0) begin void'(q0.pop_front()); p0 = 0; end
      if (p1) begin void'(q1.pop_front()); p1 = 0; end
      if (gnt0 === 1'b1 && gnt1 === 1'b1) dbl++;
      if (gnt0 === 1'b1) begin gcyc.push_back(c); gid.push_back(0); p0 = 1; end
      if (gnt1 === 1'b1) begin gcyc.push_back(c); gid.push_back(1); p1 = 1; end
      if (rvalid0 === 1'b1) rd0.push_back(rdata0);
      if (rvalid1 === 1'b1) rd1.push_back(rdata1);
      req0 = (q0.size() != 0);
      if (req0) begin we0 = q0[0].we; addr0 = q0[0].addr; din0 = q0[0].din; end
      req1 = (q1.size() != 0);
      if (req1) begin we1 = q1[0].we; addr1 = q1[0].addr; din1 = q1[0].din; end
    end
    vec++;
    if (q0.size() != 0 || q1.size() != 0 || dbl != 0) begin
      miss++;
      $display("FAIL run_done: left %0d/%0d double %0d want 0/0 0",
               q0.size(), q1.size(), dbl);
    end
  endtask

  task automatic check_grants(input string nm, input int ids[$], input int cyc[$]);
    vec++;
    if (gid.size() != ids.size()) begin
      miss++;
      $display("FAIL %s_count: got %0d want %0d", nm, gid.size(), ids.size());
    end else begin
      for (int i = 0; i < ids.size(); i++) begin
        vec++;
        if (gid[i] !== ids[i] || gcyc[i] !== cyc[i]) begin
          miss++;
          $display("FAIL %s_%0d: got id %0d cyc %0d want id %0d cyc %0d",
                   nm, i, gid[i], gcyc[i], ids[i], cyc[i]);
        end
      end
    end
  endtask

  task automatic check_rd(input string nm, input logic [7:0] got[$],
                          input logic [7:0] exp[$]);
    vec++;
    if (got.size() != exp.size()) begin
      miss++;
      $display("FAIL %s_count: got %0d want %0d", nm, got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        vec++;
        if (got[i] !== exp[i]) begin
          miss++;
          $display("FAIL %s_%0d: got %h want %h", nm, i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_contention();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q0.push_back('{we: 1'b1, addr: 4'd4, din: 8'h55});
    q1.push_back('{we: 1'b0, addr: 4'd4, din: 8'h00});
    run(12);
    check_grants("cont_gnt", '{0, 1}, '{2, 2 + GAP});
    check_rd("cont_rd1", rd1, '{8'h55});
    check_rd("cont_rd0", rd0, '{});
  endtask

  task automatic test_alternate();
    q0.push_back('{we: 1'b1, addr: 4'd8, din: 8'h11});
    q0.push_back('{we: 1'b1, addr: 4'd9, din: 8'h22});
    q1.push_back('{we: 1'b0, addr: 4'd8, din: 8'h00});
    q1.push_back('{we: 1'b0, addr: 4'd9, din: 8'h00});
    run(14);
    check_grants("alt_gnt", '{0, 1, 0, 1},
                 '{2, 2 + GAP, 2 + 2 * GAP, 2 + 3 * GAP});
    check_rd("alt_rd1", rd1, '{8'h11, 8'h22});
    check_rd("alt_rd0", rd0, '{});
  endtask

  task automatic test_single_req1();
    q1.push_back('{we: 1'b1, addr: 4'd10, din: 8'h3C});
    q1.push_back('{we: 1'b0, addr: 4'd10, din: 8'h00});
    run(10);
    check_grants("solo_gnt", '{1, 1}, '{2, 4});
    check_rd("solo_rd1", rd1, '{8'h3C});
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_alternate();
    test_single_req1();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
